// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM command arbiter: command encodings,
// FSM state encoding and default bus widths.
package sdram_arbit_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_BA_W   = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MREG      = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

endpackage

// File: rtl/sdram_arbit.sv
// Arbitrates the SDRAM command pins between init, auto-refresh, write and
// read engines; owns the DQ tri-state driver.
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BA_W   = DEF_BA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              aref_end,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_end,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_end,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    state_t state_reg;
    state_t state_next;

    logic [3:0] cmd_sel;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Each grant always returns through ARBIT, guaranteeing a NOP between bursts.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (init_end) state_next = ST_ARBIT;
            ST_ARBIT: begin
                if (aref_req)     state_next = ST_AREF;
                else if (wr_req)  state_next = ST_WRITE;
                else if (rd_req)  state_next = ST_READ;
            end
            ST_AREF:  if (aref_end) state_next = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_next = ST_ARBIT;
            ST_READ:  if (rd_end)   state_next = ST_ARBIT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_sel    = CMD_NOP;
        sdram_bank = '1;
        sdram_addr = '1;
        case (state_reg)
            ST_IDLE: begin
                cmd_sel    = init_cmd;
                sdram_bank = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd_sel    = aref_cmd;
                sdram_bank = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd_sel    = wr_cmd;
                sdram_bank = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                cmd_sel    = rd_cmd;
                sdram_bank = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd_sel    = CMD_NOP;
                sdram_bank = '1;
                sdram_addr = '1;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;

    assign aref_en   = (state_reg == ST_AREF);
    assign wr_en     = (state_reg == ST_WRITE);
    assign rd_en     = (state_reg == ST_READ);
    assign sdram_cke = sys_rst_n;

    assign sdram_dq = (state_reg == ST_WRITE && wr_sdram_en) ? wr_sdram_data : 'z;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed-vector bench for sdram_arbit: stimulus queues the expected pin
// state for each cycle, a negedge monitor pops and compares it.
module tb_sdram_arbit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
    logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  bank;
    logic [11:0] addr;
    wire  [15:0] dq;
    logic        ext_drive;

    // When the arbiter should release DQ the bench pulls it to zero, so any
    // stray drive from the DUT shows up as a non-zero value.
    assign dq = ext_drive ? 16'h0000 : 16'hzzzz;

    always #10 clk = ~clk;

    sdram_arbit dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .init_cmd      (init_cmd),
        .init_ba       (init_ba),
        .init_addr     (init_addr),
        .init_end      (init_end),
        .aref_req      (aref_req),
        .aref_cmd      (aref_cmd),
        .aref_ba       (aref_ba),
        .aref_addr     (aref_addr),
        .aref_end      (aref_end),
        .wr_req        (wr_req),
        .wr_cmd        (wr_cmd),
        .wr_ba         (wr_ba),
        .wr_addr       (wr_addr),
        .wr_end        (wr_end),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .rd_req        (rd_req),
        .rd_cmd        (rd_cmd),
        .rd_ba         (rd_ba),
        .rd_addr       (rd_addr),
        .rd_end        (rd_end),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .sdram_cke     (cke),
        .sdram_cs_n    (cs_n),
        .sdram_ras_n   (ras_n),
        .sdram_cas_n   (cas_n),
        .sdram_we_n    (we_n),
        .sdram_bank    (bank),
        .sdram_addr    (addr),
        .sdram_dq      (dq)
    );

    typedef struct {
        string       name;
        logic [37:0] exp;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // {cke, aref_en, wr_en, rd_en, cmd, bank, addr, dq}
    function automatic logic [37:0] ex(logic c, logic [2:0] en, logic [3:0] cmd,
                                       logic [1:0] ba, logic [11:0] ad, logic [15:0] d);
        return {c, en, cmd, ba, ad, d};
    endfunction

    function automatic logic [37:0] e_idle(logic c);
        return ex(c, 3'b000, 4'b0010, 2'd1, 12'h400, 16'h0000);
    endfunction

    function automatic logic [37:0] e_arb();
        return ex(1'b1, 3'b000, 4'b0111, 2'd3, 12'hFFF, 16'h0000);
    endfunction

    function automatic logic [37:0] e_aref();
        return ex(1'b1, 3'b100, 4'b0001, 2'd0, 12'h000, 16'h0000);
    endfunction

    function automatic logic [37:0] e_wr(logic [15:0] d);
        return ex(1'b1, 3'b010, 4'b0100, 2'd2, 12'h123, d);
    endfunction

    function automatic logic [37:0] e_rd();
        return ex(1'b1, 3'b001, 4'b0101, 2'd3, 12'h056, 16'h0000);
    endfunction

    // Queue this cycle's expectation, then advance to just past the next edge.
    task automatic step(input string name, input logic [37:0] e, input logic dut_drives);
        item_t it;
        ext_drive = !dut_drives;
        it.name = name;
        it.exp  = e;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            logic [37:0] act;
            it  = q.pop_front();
            act = {cke, aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n, bank, addr, dq};
            n_checks++;
            if (act === it.exp) begin
                n_pass++;
                $display("ok   %-14s pins=%h", it.name, act);
            end else begin
                $display("FAIL %-14s got=%h expected=%h", it.name, act, it.exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ext_drive = 1'b1;
        init_cmd = 4'b0010; init_ba = 2'd1; init_addr = 12'h400;
        aref_cmd = 4'b0001; aref_ba = 2'd0; aref_addr = 12'h000;
        wr_cmd   = 4'b0100; wr_ba   = 2'd2; wr_addr   = 12'h123;
        rd_cmd   = 4'b0101; rd_ba   = 2'd3; rd_addr   = 12'h056;
        {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = '0;
        wr_sdram_en = 1'b0;
        wr_sdram_data = 16'h1234;
        @(posedge clk);
        #1;

        step("reset", e_idle(1'b0), 1'b0);
        rst_n = 1'b1;
        step("idle_init", e_idle(1'b1), 1'b0);
        init_end = 1'b1;
        step("idle_end", e_idle(1'b1), 1'b0);
        step("arbit_nop", e_arb(), 1'b0);
        {aref_req, wr_req, rd_req} = 3'b111;
        step("arbit_allreq", e_arb(), 1'b0);
        aref_req = 1'b0;
        step("aref_grant", e_aref(), 1'b0);
        aref_end = 1'b1;
        step("aref_end", e_aref(), 1'b0);
        aref_end = 1'b0;
        step("arbit_gap1", e_arb(), 1'b0);
        wr_req = 1'b0;
        wr_sdram_en = 1'b1;
        step("write_dq", e_wr(16'h1234), 1'b1);
        wr_sdram_en = 1'b0;
        {rd_end, aref_end} = 2'b11;
        step("write_dq_z", e_wr(16'h0000), 1'b0);
        {rd_end, aref_end} = 2'b00;
        {wr_end, aref_req} = 2'b11;
        step("write_end", e_wr(16'h0000), 1'b0);
        wr_end = 1'b0;
        step("arbit_gap2", e_arb(), 1'b0);
        aref_req = 1'b0;
        aref_end = 1'b1;
        step("aref_2", e_aref(), 1'b0);
        aref_end = 1'b0;
        step("arbit_rd", e_arb(), 1'b0);
        rd_req = 1'b0;
        aref_req = 1'b1;
        step("read_hold", e_rd(), 1'b0);
        rd_end = 1'b1;
        step("read_end", e_rd(), 1'b0);
        rd_end = 1'b0;
        step("arbit_gap3", e_arb(), 1'b0);
        aref_req = 1'b0;
        aref_end = 1'b1;
        step("aref_3", e_aref(), 1'b0);
        aref_end = 1'b0;
        wr_end = 1'b1;
        step("arbit_stray", e_arb(), 1'b0);
        wr_end = 1'b0;
        wr_req = 1'b1;
        step("arbit_stay", e_arb(), 1'b0);
        wr_req = 1'b0;
        wr_sdram_en = 1'b1;
        wr_sdram_data = 16'hBEEF;
        step("write_2", e_wr(16'hBEEF), 1'b1);
        init_end = 1'b0;
        rst_n = 1'b0;
        step("reset_mid_wr", e_idle(1'b0), 1'b0);
        rst_n = 1'b1;
        wr_sdram_en = 1'b0;
        step("post_reset", e_idle(1'b1), 1'b0);
        step("idle_wait", e_idle(1'b1), 1'b0);
        init_end = 1'b1;
        step("idle_end2", e_idle(1'b1), 1'b0);
        step("arbit_again", e_arb(), 1'b0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain got=%0d expected=0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
